// File: rtl/io_input_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_input_capture_if
//  Brief    : CPU-facing request/data bundle of the IN-operation capture block.
//  Revision : 1.0  initial release
// ============================================================================

interface io_input_capture_if;
    logic        read_req;
    logic [31:0] data_out;
    logic        data_valid;
    logic        stall;
    logic        waiting;
    logic        timed_out;

    // master = processor side, slave = capture block
    modport master (
        output read_req,
        input  data_out,
        input  data_valid,
        input  stall,
        input  waiting,
        input  timed_out
    );

    modport slave (
        input  read_req,
        output data_out,
        output data_valid,
        output stall,
        output waiting,
        output timed_out
    );
endinterface

`default_nettype wire

// File: rtl/io_input_capture.sv
`default_nettype none
// ============================================================================
//  Module   : io_input_capture
//  Brief    : Debounced switch/key capture that stalls the CPU during an IN
//             operation and delivers one sign-extended 32-bit word.
//             Optional macro IO_INPUT_TIMEOUT_EN adds an auto-complete timeout.
//  Revision : 1.0  initial release
// ============================================================================

module io_input_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_n,
    input  logic [17:0]        switches,
    io_input_capture_if.slave  cpu
);

    generate
        if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("io_input_capture: DEBOUNCE_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    localparam int                c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_DONE         = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: 2-FF synchronizer followed by a stability counter
    // ------------------------------------------------------------------
    logic              r_key_meta;
    logic              r_key_sync;
    logic              r_key_db;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_db_flip;
    logic              w_press;
    logic              w_release;

    // The flip event itself is the strobe, so the FSM reacts on the same
    // edge the debounced level changes.
    assign w_db_flip = (r_key_sync != r_key_db) && (r_db_cnt == c_DB_LAST);
    assign w_press   = w_db_flip &  r_key_db;
    assign w_release = w_db_flip & ~r_key_db;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
            r_key_db   <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
            if (r_key_sync == r_key_db) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_key_db <= r_key_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_capture;
    logic   w_to_done;
    logic   w_timeout_hit;

`ifdef IO_INPUT_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Held at zero outside WAIT_PRESS so every entry starts a fresh window.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_PRESS) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LAST) begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    assign w_timeout_hit = (r_state == S_WAIT_PRESS) && (r_to_cnt == c_TO_LAST);
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort on a dropped request outranks press/release; press outranks timeout.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_to_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu.read_req) begin
                    w_state_next = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                if (!cpu.read_req) begin
                    w_state_next = S_IDLE;
                end else if (w_press) begin
                    w_capture    = 1'b1;
                    w_state_next = S_WAIT_RELEASE;
                end else if (w_timeout_hit) begin
                    w_capture    = 1'b1;
                    w_to_done    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_WAIT_RELEASE: begin
                if (!cpu.read_req) begin
                    w_state_next = S_IDLE;
                end else if (w_release) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured word and completion cause
    // ------------------------------------------------------------------
    logic [31:0] r_data;
    logic        r_timed_out;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data      <= 32'd0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data <= {{14{switches[17]}}, switches};
            end
            if (w_state_next == S_DONE) begin
                r_timed_out <= w_to_done;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu.data_out   = r_data;
    assign cpu.data_valid = (r_state == S_DONE);
    // Gated by reset so a pending request does not freeze the CPU while held in reset.
    assign cpu.stall      = reset & cpu.read_req & (r_state != S_DONE);
    assign cpu.waiting    = (r_state == S_WAIT_PRESS) || (r_state == S_WAIT_RELEASE);
    assign cpu.timed_out  = r_timed_out;

endmodule

`default_nettype wire
